stream_driver: RTL and testbench

Parametrised, synthesizable successor to the testbench channel driver. It buffers incoming transactions (data plus channel ID) in an internal FIFO and drives them onto a valid/ready output with AXI-stream-style stability rules. It supports back-to-back transfers, a programmable idle gap between transfers, a transfer counter and a ready-timeout error flag. It sits between stimulus generators and the proxy/DUT input in the combinational verification environment.

---
 rtl/stream_driver.sv | 149 ++++++++++++++
 tb/tb_stream_driver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_driver.sv
// rtl/stream_driver.sv - FIFO-buffered valid/ready stream driver with idle gap, transfer count and ready timeout
// The output register is loaded only from FIFO storage; data/channel_id change only when an entry is popped.
module stream_driver #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2,
  parameter int DEPTH  = 4,
  parameter int GAP_W  = 4,
  parameter int TMO    = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [GAP_W-1:0]         gap,
  output logic [DATA_W-1:0]        data,
  output logic [CH_W-1:0]          channel_id,
  output logic                     valid,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              sent_cnt,
  output logic                     timeout,
  output logic                     busy
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int TW     = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam bit TMO_EN = (TMO != 0);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [CH_W-1:0]   mem_ch   [DEPTH];

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]   ch_q;
  logic              valid_q, valid_d;
  logic [15:0]       sent_q;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              timeout_q, timeout_d;

  logic push, pop, xfer, level_nz;

  assign level_nz = (level_q != '0);
  assign in_ready = (level_q < LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign xfer     = (state_q == S_DRIVE) && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (level_nz) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (ready) begin
          if (gap != '0)     state_d = S_GAP;
          else if (!level_nz) state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The wait counter saturates at TMO so the sticky flag never has to track wrap-around.
  always_comb begin
    pop       = ((state_q == S_IDLE) || (xfer && (gap == '0))) && level_nz;
    valid_d   = (state_d == S_DRIVE);
    gap_cnt_d = gap_cnt_q;
    if (xfer) begin
      gap_cnt_d = gap;
    end else if (state_q == S_GAP) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end
    wait_d = wait_q;
    if (pop || xfer) begin
      wait_d = '0;
    end else if ((state_q == S_DRIVE) && (wait_q != TW'(TMO))) begin
      wait_d = wait_q + TW'(1);
    end
    timeout_d = timeout_q || (TMO_EN && (state_q == S_DRIVE) && !ready && (wait_d == TW'(TMO)));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_ch[wr_ptr_q]   <= in_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      data_q    <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      sent_q    <= '0;
      gap_cnt_q <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (pop) begin
        data_q <= mem_data[rd_ptr_q];
        ch_q   <= mem_ch[rd_ptr_q];
      end
      if (xfer) sent_q <= sent_q + 16'd1;
      valid_q   <= valid_d;
      gap_cnt_q <= gap_cnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign data       = data_q;
  assign channel_id = ch_q;
  assign valid      = valid_q;
  assign level      = level_q;
  assign sent_cnt   = sent_q;
  assign timeout    = timeout_q;
  assign busy       = valid_q || level_nz || (state_q == S_GAP);

endmodule

// File: tb/tb_stream_driver.sv
// tb/tb_stream_driver.sv - self-checking bench for stream_driver
// Two instances share stimulus: default TMO=256 and a short TMO=8 for the timeout flag.
module tb_stream_driver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_ch = '0;
  logic [3:0] gap = '0;
  logic       ready = 1'b0;

  logic        in_ready, valid, timeout, busy;
  logic [7:0]  data;
  logic [1:0]  channel_id;
  logic [2:0]  level;
  logic [15:0] sent_cnt;
  logic        a_in_ready, a_valid, a_timeout, a_busy;
  logic [7:0]  a_data;
  logic [1:0]  a_channel_id;
  logic [2:0]  a_level;
  logic [15:0] a_sent_cnt;

  stream_driver #(.DATA_W(8), .CH_W(2), .DEPTH(DEPTH), .GAP_W(4), .TMO(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .gap(gap), .data(data), .channel_id(channel_id), .valid(valid),
    .ready(ready), .level(level), .sent_cnt(sent_cnt), .timeout(timeout), .busy(busy)
  );

  stream_driver #(.DATA_W(8), .CH_W(2), .DEPTH(DEPTH), .GAP_W(4), .TMO(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_ch(in_ch), .gap(gap), .data(a_data), .channel_id(a_channel_id), .valid(a_valid),
    .ready(ready), .level(a_level), .sent_cnt(a_sent_cnt), .timeout(a_timeout), .busy(a_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending entries, output slot, and an idle countdown.
  logic [9:0] mq[$];
  bit         m_valid;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_sent, m_wait, m_cool;
  bit         m_to, m_to8;

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_data = '0; m_ch = '0;
    m_sent = 0; m_wait = 0; m_cool = 0; m_to = 0; m_to8 = 0;
  endtask

  task automatic model_load();
    logic [9:0] e;
    e = mq.pop_front();
    m_data = e[9:2]; m_ch = e[1:0]; m_valid = 1; m_wait = 0;
  endtask

  task automatic model_step();
    int sz;
    bit acc;
    sz  = mq.size();
    acc = in_valid && (sz < DEPTH);
    if (m_valid) begin
      if (ready) begin
        m_sent = (m_sent + 1) % 65536;
        m_wait = 0;
        if (gap == 0 && sz > 0) model_load();
        else begin m_valid = 0; m_cool = int'(gap); end
      end else begin
        m_wait++;
        if (m_wait >= 256) m_to = 1;
        if (m_wait >= 8) m_to8 = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (sz > 0) begin
      model_load();
    end
    if (acc) mq.push_back({in_data, in_ch});
  endtask

  task automatic compare_all();
    check("valid", valid, m_valid);
    check("data", data, m_data);
    check("channel_id", channel_id, m_ch);
    check("level", level, mq.size());
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("sent_cnt", sent_cnt, m_sent);
    check("timeout", timeout, m_to);
    check("busy", busy, m_valid || mq.size() > 0 || m_cool > 0);
    check("timeout8", a_timeout, m_to8);
    check("valid8", a_valid, m_valid);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    in_valid = 0; ready = 0; gap = '0;
    rst_n = 0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct {
    int iv, id, ic, rdy, g;
    int ev, ed, ech, elv, esent, ebusy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int iv, id, ic, rdy, g, ev, ed, ech, elv, esent, ebusy);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.rdy = rdy; v.g = g;
    v.ev = ev; v.ed = ed; v.ech = ech; v.elv = elv; v.esent = esent; v.ebusy = ebusy;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p;
    // Single transaction followed by three entries with gap=2.
    add(1, 8'hA5, 2, 1, 0,  0, 8'h00, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0,      1, 8'hA5, 2, 0, 0, 1);
    add(0, 0, 0, 1, 0,      0, 8'hA5, 2, 0, 1, 0);
    add(0, 0, 0, 1, 0,      0, 8'hA5, 2, 0, 1, 0);
    add(1, 8'h01, 1, 0, 0,  0, 8'hA5, 2, 1, 1, 1);
    add(1, 8'h02, 2, 0, 0,  1, 8'h01, 1, 1, 1, 1);
    add(1, 8'h03, 3, 0, 0,  1, 8'h01, 1, 2, 1, 1);
    add(0, 0, 0, 1, 2,      0, 8'h01, 1, 2, 2, 1);
    add(0, 0, 0, 1, 2,      0, 8'h01, 1, 2, 2, 1);
    add(0, 0, 0, 1, 2,      0, 8'h01, 1, 2, 2, 1);
    add(0, 0, 0, 1, 2,      1, 8'h02, 2, 1, 2, 1);
    add(0, 0, 0, 1, 2,      0, 8'h02, 2, 1, 3, 1);
    add(0, 0, 0, 1, 2,      0, 8'h02, 2, 1, 3, 1);
    add(0, 0, 0, 1, 2,      0, 8'h02, 2, 1, 3, 1);
    add(0, 0, 0, 1, 2,      1, 8'h03, 3, 0, 3, 1);
    add(0, 0, 0, 1, 0,      0, 8'h03, 3, 0, 4, 0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_channel_id", channel_id, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv[0];
      in_data  = 8'(tbl[i].id);
      in_ch    = 2'(tbl[i].ic);
      ready    = tbl[i].rdy[0];
      gap      = 4'(tbl[i].g);
      tick();
      check("tbl_valid", valid, tbl[i].ev);
      check("tbl_data", data, tbl[i].ed);
      check("tbl_channel_id", channel_id, tbl[i].ech);
      check("tbl_level", level, tbl[i].elv);
      check("tbl_sent_cnt", sent_cnt, tbl[i].esent);
      check("tbl_busy", busy, tbl[i].ebusy);
    end
    in_valid = 0;

    // Backpressure with timeout on the TMO=8 instance only.
    do_reset();
    in_valid = 1; in_data = 8'h11; in_ch = 2'd1;
    tick();
    in_valid = 0;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("bp_valid", valid, 1);
      check("bp_data", data, 8'h11);
      check("bp_channel_id", channel_id, 1);
      check("bp_timeout", timeout, 0);
      check("tmo8_rise", a_timeout, (k >= 8) ? 1 : 0);
    end
    ready = 1;
    tick();
    check("bp_sent", sent_cnt, 1);
    check("bp_valid_drop", valid, 0);
    check("tmo8_sticky", a_timeout, 1);
    tick();
    check("bp_one_xfer", sent_cnt, 1);
    check("tmo8_sticky2", a_timeout, 1);

    // Fill FIFO plus output register, one extra push must be refused.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = 8'(8'h40 + i); in_ch = 2'(i);
      tick();
      check("full_in_ready", in_ready, (i >= 4) ? 0 : 1);
    end
    in_valid = 0;
    check("full_level", level, DEPTH);
    ready = 1;
    for (int i = 0; i < 5; i++) begin
      check("stream_valid", valid, 1);
      check("stream_data", data, 8'h40 + i);
      tick();
    end
    check("stream_end_valid", valid, 0);
    check("stream_sent", sent_cnt, 5);

    // Asynchronous reset while a transaction is in flight.
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'(8'h70 + i); in_ch = 2'(i);
      tick();
    end
    in_valid = 0;
    tick();
    check("mid_pre_valid", valid, 1);
    #2 rst_n = 0;
    #1;
    check("mid_valid", valid, 0);
    check("mid_level", level, 0);
    check("mid_sent", sent_cnt, 0);
    check("mid_busy", busy, 0);
    check("mid_in_ready", in_ready, 1);
    model_reset();
    rst_n = 1;
    ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_idle", valid, 0);
    end
    in_valid = 1; in_data = 8'h3C; in_ch = 2'd3;
    tick();
    in_valid = 0;
    tick();
    check("post_rst_push", data, 8'h3C);

    // Randomized traffic against the model.
    do_reset();
    p = 80;
    for (int n = 0; n < 3000; n++) begin
      if (n % 40 == 0) p = $urandom_range(0, 4) * 25;
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = 8'($urandom);
      in_ch    = 2'($urandom);
      ready    = ($urandom_range(0, 99) < p);
      gap      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
